// File: rtl/dmem_copy_master.sv
// Word-copy initiator for the single-port data memory: one read cycle plus one write cycle per word, with abort.
// Optional DMEM_COPY_FILL_EN adds a fill mode that writes a latched pattern word on every cycle, with no read cycles.
module dmem_copy_master #(
    parameter int LEN_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      cmd_src,
    input  logic [31:0]      cmd_dst,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_fill,
    input  logic [31:0]      cmd_pattern,
    output logic [31:0]      mem_addr,
    output logic             mem_wr_en,
    output logic [31:0]      mem_wr_data,
    input  logic [31:0]      mem_rd_data,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [LEN_W-1:0] words_done
);

    typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

    state_t           state, state_nxt;
    logic [31:0]      src, dst, rd_buf;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] words_inc;
    logic             last_word;
    logic             fill_mode;
    logic             fill_start;
    logic [31:0]      pattern;

    assign words_inc = words_done + {{(LEN_W-1){1'b0}}, 1'b1};
    assign last_word = (words_inc == len);

`ifdef DMEM_COPY_FILL_EN
    assign fill_start = cmd_fill;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_mode <= 1'b0;
            pattern   <= 32'd0;
        end else if (state == IDLE && start) begin
            fill_mode <= cmd_fill;
            pattern   <= cmd_pattern;
        end
    end

    logic unused_bits;
    assign unused_bits = &{1'b0, cmd_src[1:0], cmd_dst[1:0]};
`else
    assign fill_start = 1'b0;
    assign fill_mode  = 1'b0;
    assign pattern    = 32'd0;

    logic unused_bits;
    assign unused_bits = &{1'b0, cmd_src[1:0], cmd_dst[1:0], cmd_fill, cmd_pattern};
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (cmd_len == '0) ? FIN : (fill_start ? WR : RD);
            RD:   state_nxt = abort ? IDLE : WR;
            WR: begin
                if (abort)          state_nxt = IDLE;
                else if (last_word) state_nxt = FIN;
                else                state_nxt = fill_mode ? WR : RD;
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Port outputs decode straight from state so an async reset drops mem_wr_en at once.
    always_comb begin
        mem_addr    = 32'd0;
        mem_wr_en   = 1'b0;
        mem_wr_data = 32'd0;
        case (state)
            RD: mem_addr = src;
            WR: begin
                mem_addr    = dst;
                mem_wr_en   = 1'b1;
                mem_wr_data = fill_mode ? pattern : rd_buf;
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == FIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            src        <= 32'd0;
            dst        <= 32'd0;
            len        <= '0;
            rd_buf     <= 32'd0;
            words_done <= '0;
            aborted    <= 1'b0;
        end else begin
            state   <= state_nxt;
            aborted <= abort && (state == RD || state == WR);
            case (state)
                IDLE: if (start) begin
                    src        <= {cmd_src[31:2], 2'b00};
                    dst        <= {cmd_dst[31:2], 2'b00};
                    len        <= cmd_len;
                    words_done <= '0;
                end
                RD: begin
                    rd_buf <= mem_rd_data;
                    src    <= src + 32'd4;
                end
                // A write in the abort cycle still lands in memory, so it is counted.
                WR: begin
                    dst        <= dst + 32'd4;
                    words_done <= words_inc;
                end
                default: ;
            endcase
        end
    end

endmodule
